eth_fcs_rx_ctrl: RTL
====================

// Module: eth_fcs_rx_ctrl
// PURPOSE
// Receive-side sequencer for the byte-wise CRC-32 engine in the UDP path.
// - Tracks GMII-style rx bytes and detects preamble/SFD.
// - Initialises the CRC engine per frame and enables it for every byte after SFD.
// - Checks the CRC residue at end of frame.
// - Forwards the frame downstream with the 4 FCS bytes stripped, tagged SOF/EOF and good/bad.
// PARAMETERS
// RESIDUE    32'hC704_DD7B  engine value after data+FCS of a good frame (init FFFF_FFFF, no final xor)
// MIN_BYTES  64             min frame length after SFD incl. FCS; shorter = runt (bad)
// MAX_BYTES  1518           max frame length after SFD incl. FCS; longer = oversize (abort)
// PORTS
// CLK         in   1   clock
// reset       in   1   synchronous, active-low
// rx_dv       in   1   rx byte valid (contiguous per frame)
// rx_er       in   1   rx error, sampled while rx_dv=1
// rxd         in   8   rx byte
// crc_d       out  8   byte to CRC engine (= rxd, combinational)
// crc_flg     out  1   CRC engine byte enable
// crc_rst_n   out  1   CRC engine sync active-low init (loads FFFF_FFFF)
// crc_value   in   32  CRC engine register
// out_valid   out  1   payload byte strobe
// out_data    out  8   payload byte
// out_sof     out  1   first payload byte of frame
// out_eof     out  1   last payload byte of frame
// out_fcs_ok  out  1   valid with out_eof: 1 = good frame
// good_cnt    out  16  good frames, wraps
// bad_cnt     out  16  bad/aborted frames, wraps
// BEHAVIOUR
// - Reset (reset=0 at edge):
//   - state IDLE; all out_* = 0; counters = 0.
//   - crc_rst_n = 0 combinationally while reset=0.
// - States: IDLE, PRE, DATA, CHECK, DROP.
// - IDLE:
//   - rx_dv & rxd=55 -> PRE.
//   - rx_dv & rxd=D5 -> DATA, with crc_rst_n=0 that cycle.
//   - rx_dv & other byte -> DROP.
// - PRE:
//   - rxd=55 stays in PRE.
//   - rxd=D5 -> DATA, with crc_rst_n=0 that cycle.
//   - Other byte, or rx_dv=0 -> DROP/IDLE. No counter change.
// - DATA, per byte with rx_dv=1:
//   - crc_flg=1.
//   - byte pushed into a 5-deep delay line; len increments, saturating at MAX_BYTES+1.
//   - Once 5 bytes are held, each push emits the oldest byte next cycle (out_valid=1).
//   - out_sof=1 on the first emitted byte of a frame.
//   - rx_er=1 sets a sticky err flag.
// - DATA, rx_dv falls -> CHECK:
//   - crc_value now includes the last byte.
//   - bad = err | len<MIN_BYTES | crc_value!=RESIDUE.
// - CHECK, one cycle:
//   - If len>=5: next cycle emit the 5th-oldest byte (last payload byte) with out_eof=1 and out_fcs_ok=~bad.
//   - The 4 FCS bytes are discarded.
//   - If len<5: nothing is emitted.
//   - Exactly one of good_cnt/bad_cnt increments; then -> IDLE.
// - Oversize: when len would exceed MAX_BYTES:
//   - Emit the pending byte with out_eof=1 and out_fcs_ok=0.
//   - bad_cnt++; -> DROP.
// - DROP:
//   - crc_flg=0, no output; wait for rx_dv=0, then -> IDLE.
// - Latency: payload byte appears on out_data 5 bytes after it enters on rxd. EOF is 2 cycles after rx_dv falls.
// - A new SFD in the cycle right after CHECK is accepted: IDLE must see rx_dv the cycle after CHECK.
// - Reset mid-frame: outputs cleared next cycle, no EOF emitted, counters zeroed.
// - All out_* are registered; out_eof/out_fcs_ok/out_sof are 0 when out_valid=0.
// TESTING
// - MIN_BYTES=5: 7x55,D5,31..39,26 39 F4 CB -> 9 bytes 31..39 out, sof on 31, eof on 39, fcs_ok=1, good_cnt=1.
// - Same frame with last FCS byte CA -> identical data, eof fcs_ok=0, bad_cnt=1.
// - Default params: 60x00 + correct FCS -> 60 bytes out, fcs_ok=1. Same 20 bytes + FCS -> runt, fcs_ok=0.
// - rx_er pulsed on byte 10 of good 64-byte frame -> full payload out, fcs_ok=0, bad_cnt++.
// - MAX_BYTES=20, 30-byte frame -> eof with fcs_ok=0 at byte 16, no further out_valid, bad_cnt=1.
// - Preamble 55,55,AA -> no output, no counter change. Back-to-back frames with 1-cycle gap -> both checked.

Source files
------------

// File: rtl/eth_fcs_rx_ctrl_if.sv
// Receive byte stream, CRC engine hookup and stripped payload stream of eth_fcs_rx_ctrl.
interface eth_fcs_rx_ctrl_if;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic [7:0]  crc_d;
    logic        crc_flg;
    logic        crc_rst_n;
    logic [31:0] crc_value;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_fcs_ok;

    modport slave (
        input  rx_dv, rx_er, rxd, crc_value,
        output crc_d, crc_flg, crc_rst_n,
        output out_valid, out_data, out_sof, out_eof, out_fcs_ok
    );

    modport master (
        output rx_dv, rx_er, rxd, crc_value,
        input  crc_d, crc_flg, crc_rst_n,
        input  out_valid, out_data, out_sof, out_eof, out_fcs_ok
    );
endinterface

// File: rtl/eth_fcs_rx_ctrl.sv
// Rx FCS sequencer: finds preamble/SFD, drives the external CRC-32 engine, strips the FCS
// through a 5-byte delay line and tags the payload with SOF/EOF and good/bad status.
module eth_fcs_rx_ctrl #(
    parameter logic [31:0] RESIDUE   = 32'hC704_DD7B,
    parameter int unsigned MIN_BYTES = 64,
    parameter int unsigned MAX_BYTES = 1518
) (
    input  logic               CLK,
    input  logic               reset,
    eth_fcs_rx_ctrl_if.slave   bus,
    output logic [15:0]        good_cnt,
    output logic [15:0]        bad_cnt
);

    localparam int unsigned LenW = $clog2(MAX_BYTES + 2);
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_BYTES);
    localparam logic [LenW-1:0] MinLen = LenW'(MIN_BYTES);
    localparam logic [7:0] PreByte = 8'h55;
    localparam logic [7:0] SfdByte = 8'hD5;

    typedef enum logic [2:0] {StIdle, StPre, StData, StCheck, StDrop} state_e;

    state_e          state_q, state_d;
    logic [LenW-1:0] len_q, len_d;
    logic            err_q, err_d;
    logic            bad_q, bad_d;
    logic            sof_q, sof_d;
    logic [2:0]      held_q, held_d;
    logic [4:0][7:0] dly_q, dly_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eof_q, out_eof_d;
    logic            out_ok_q, out_ok_d;
    logic [15:0]     good_q, good_d;
    logic [15:0]     badc_q, badc_d;
    logic            crc_en;
    logic            crc_init;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        err_d       = err_q;
        bad_d       = bad_q;
        sof_d       = sof_q;
        held_d      = held_q;
        dly_d       = dly_q;
        out_valid_d = 1'b0;
        out_data_d  = 8'h00;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_ok_d    = 1'b0;
        good_d      = good_q;
        badc_d      = badc_q;
        crc_en      = 1'b0;
        crc_init    = 1'b0;

        unique case (state_q)
            StIdle, StPre: begin
                if (!bus.rx_dv) begin
                    state_d = StIdle;
                end else if (bus.rxd == SfdByte) begin
                    crc_init = 1'b1;
                    len_d    = '0;
                    err_d    = 1'b0;
                    held_d   = 3'd0;
                    sof_d    = 1'b1;
                    state_d  = StData;
                end else if (bus.rxd == PreByte) begin
                    state_d = StPre;
                end else begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (bus.rx_dv) begin
                    crc_en = 1'b1;
                    if (len_q == MaxLen) begin
                        // Oversize: close the frame on the byte already pending, then drop.
                        if (held_q == 3'd5) begin
                            out_valid_d = 1'b1;
                            out_data_d  = dly_q[4];
                            out_sof_d   = sof_q;
                            out_eof_d   = 1'b1;
                        end
                        badc_d  = badc_q + 16'd1;
                        state_d = StDrop;
                    end else begin
                        len_d = len_q + LenW'(1);
                        if (bus.rx_er) begin
                            err_d = 1'b1;
                        end
                        dly_d = {dly_q[3:0], bus.rxd};
                        if (held_q == 3'd5) begin
                            out_valid_d = 1'b1;
                            out_data_d  = dly_q[4];
                            out_sof_d   = sof_q;
                            sof_d       = 1'b0;
                        end else begin
                            held_d = held_q + 3'd1;
                        end
                    end
                end else begin
                    bad_d   = err_q | (len_q < MinLen) | (bus.crc_value != RESIDUE);
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Oldest held byte is the last payload byte; the other four are the FCS.
                if (held_q == 3'd5) begin
                    out_valid_d = 1'b1;
                    out_data_d  = dly_q[4];
                    out_sof_d   = sof_q;
                    out_eof_d   = 1'b1;
                    out_ok_d    = ~bad_q;
                end
                if (bad_q) begin
                    badc_d = badc_q + 16'd1;
                end else begin
                    good_d = good_q + 16'd1;
                end
                state_d = StIdle;
            end
            StDrop: begin
                if (!bus.rx_dv) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            err_q       <= 1'b0;
            bad_q       <= 1'b0;
            sof_q       <= 1'b0;
            held_q      <= 3'd0;
            dly_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_ok_q    <= 1'b0;
            good_q      <= 16'd0;
            badc_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            err_q       <= err_d;
            bad_q       <= bad_d;
            sof_q       <= sof_d;
            held_q      <= held_d;
            dly_q       <= dly_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_ok_q    <= out_ok_d;
            good_q      <= good_d;
            badc_q      <= badc_d;
        end
    end

    assign bus.crc_d      = bus.rxd;
    assign bus.crc_flg    = crc_en;
    assign bus.crc_rst_n  = reset & ~crc_init;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.out_eof    = out_eof_q;
    assign bus.out_fcs_ok = out_ok_q;
    assign good_cnt       = good_q;
    assign bad_cnt        = badc_q;

endmodule
